// File: rtl/oai222_vector_sweeper_if.sv
// Signal bundle between the OAI222 vector sweeper and the cell under test / its host.
// master: sweeper side, slave: cell/host side.
interface oai222_vector_sweeper_if;
    logic       START;
    logic       ZN_IN;
    logic       A1;
    logic       A2;
    logic       B1;
    logic       B2;
    logic       C1;
    logic       C2;
    logic       BUSY;
    logic       DONE;
    logic [6:0] ERR_CNT;
    logic       FIRST_ERR_VLD;
    logic [5:0] FIRST_ERR_VEC;

    modport master (
        input  START, ZN_IN,
        output A1, A2, B1, B2, C1, C2,
        output BUSY, DONE, ERR_CNT, FIRST_ERR_VLD, FIRST_ERR_VEC
    );

    modport slave (
        output START, ZN_IN,
        input  A1, A2, B1, B2, C1, C2,
        input  BUSY, DONE, ERR_CNT, FIRST_ERR_VLD, FIRST_ERR_VEC
    );
endinterface

// File: rtl/oai222_vector_sweeper.sv
// Exhaustive 64-vector functional sweep of an OAI222 cell, counting mismatches on ZN.
//
// state | meaning
// IDLE  | waiting for START, stimulus parked at 0
// DRIVE | current vector applied, settle counter running 1..SETTLE
// CHECK | ZN_IN compared against the expected value at the closing edge
// FIN   | sweep complete, results held until next START or reset
module oai222_vector_sweeper #(
    parameter int SETTLE = 2
) (
    input  logic                      CK,
    input  logic                      RN,
    oai222_vector_sweeper_if.master   sw
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t     state, state_nx;
    logic [5:0] vec, vec_nx;
    logic [3:0] settle_cnt, settle_cnt_nx;
    logic [5:0] stim, stim_nx;
    logic       busy, busy_nx;
    logic       done, done_nx;
    logic [6:0] err_cnt, err_cnt_nx;
    logic       first_err_vld, first_err_vld_nx;
    logic [5:0] first_err_vec, first_err_vec_nx;

    logic       exp_zn;
    logic       mismatch;

    assign exp_zn   = ~((vec[5] | vec[4]) & (vec[3] | vec[2]) & (vec[1] | vec[0]));
    assign mismatch = (sw.ZN_IN != exp_zn);

    always_ff @(posedge CK) begin
        if (!RN) begin
            state         <= IDLE;
            vec           <= 6'd0;
            settle_cnt    <= 4'd0;
            stim          <= 6'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_cnt       <= 7'd0;
            first_err_vld <= 1'b0;
            first_err_vec <= 6'd0;
        end else begin
            state         <= state_nx;
            vec           <= vec_nx;
            settle_cnt    <= settle_cnt_nx;
            stim          <= stim_nx;
            busy          <= busy_nx;
            done          <= done_nx;
            err_cnt       <= err_cnt_nx;
            first_err_vld <= first_err_vld_nx;
            first_err_vec <= first_err_vec_nx;
        end
    end

    always_comb begin
        state_nx         = state;
        vec_nx           = vec;
        settle_cnt_nx    = settle_cnt;
        stim_nx          = stim;
        busy_nx          = busy;
        done_nx          = done;
        err_cnt_nx       = err_cnt;
        first_err_vld_nx = first_err_vld;
        first_err_vec_nx = first_err_vec;

        case (state)
            IDLE, FIN: begin
                if (sw.START) begin
                    state_nx         = DRIVE;
                    vec_nx           = 6'd0;
                    settle_cnt_nx    = 4'd1;
                    stim_nx          = 6'd0;
                    busy_nx          = 1'b1;
                    done_nx          = 1'b0;
                    err_cnt_nx       = 7'd0;
                    first_err_vld_nx = 1'b0;
                    first_err_vec_nx = 6'd0;
                end
            end

            DRIVE: begin
                if (settle_cnt == SETTLE_C) begin
                    state_nx = CHECK;
                end else begin
                    settle_cnt_nx = settle_cnt + 4'd1;
                end
            end

            CHECK: begin
                if (mismatch) begin
                    err_cnt_nx = err_cnt + 7'd1;
                    if (!first_err_vld) begin
                        first_err_vld_nx = 1'b1;
                        first_err_vec_nx = vec;
                    end
                end
                // Last vector: park stimulus and leave vec at 63 rather than wrapping.
                if (vec == 6'd63) begin
                    state_nx = FIN;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    stim_nx  = 6'd0;
                end else begin
                    state_nx      = DRIVE;
                    vec_nx        = vec + 6'd1;
                    stim_nx       = vec + 6'd1;
                    settle_cnt_nx = 4'd1;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign sw.A1            = stim[5];
    assign sw.A2            = stim[4];
    assign sw.B1            = stim[3];
    assign sw.B2            = stim[2];
    assign sw.C1            = stim[1];
    assign sw.C2            = stim[0];
    assign sw.BUSY          = busy;
    assign sw.DONE          = done;
    assign sw.ERR_CNT       = err_cnt;
    assign sw.FIRST_ERR_VLD = first_err_vld;
    assign sw.FIRST_ERR_VEC = first_err_vec;

endmodule

// File: tb/tb_oai222_vector_sweeper.sv
// Scoreboard bench for oai222_vector_sweeper: golden / stuck-at cell models, SETTLE 1, 2 and 15.
module tb_oai222_vector_sweeper;

    typedef struct {
        int busy_len;
        int err;
        int vld;
        int vec;
    } exp_t;

    logic ck;
    logic rn;
    logic start;
    int   mode;      // 0 golden, 1 stuck at 1, 2 stuck at 0
    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    oai222_vector_sweeper_if sw2 ();
    oai222_vector_sweeper_if sw1 ();
    oai222_vector_sweeper_if sw15 ();

    oai222_vector_sweeper #(.SETTLE(2))  u_dut2  (.CK(ck), .RN(rn), .sw(sw2));
    oai222_vector_sweeper #(.SETTLE(1))  u_dut1  (.CK(ck), .RN(rn), .sw(sw1));
    oai222_vector_sweeper #(.SETTLE(15)) u_dut15 (.CK(ck), .RN(rn), .sw(sw15));

    assign sw2.START  = start;
    assign sw1.START  = start;
    assign sw15.START = start;

    assign sw2.ZN_IN  = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 :
                        ~((sw2.A1 | sw2.A2) & (sw2.B1 | sw2.B2) & (sw2.C1 | sw2.C2));
    assign sw1.ZN_IN  = ~((sw1.A1 | sw1.A2) & (sw1.B1 | sw1.B2) & (sw1.C1 | sw1.C2));
    assign sw15.ZN_IN = ~((sw15.A1 | sw15.A2) & (sw15.B1 | sw15.B2) & (sw15.C1 | sw15.C2));

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int stim2();
        return int'({sw2.A1, sw2.A2, sw2.B1, sw2.B2, sw2.C1, sw2.C2});
    endfunction

    function automatic int all_out2();
        return int'({sw2.A1, sw2.A2, sw2.B1, sw2.B2, sw2.C1, sw2.C2, sw2.BUSY, sw2.DONE,
                     sw2.ERR_CNT, sw2.FIRST_ERR_VLD, sw2.FIRST_ERR_VEC});
    endfunction

    // Reference result of a full sweep of the SETTLE=2 instance for a given cell model.
    function automatic exp_t model(input int m);
        exp_t       e;
        logic [5:0] v;
        logic       g;
        logic       r;
        e.busy_len = 64 * 3;
        e.err      = 0;
        e.vld      = 0;
        e.vec      = 0;
        for (int i = 0; i < 64; i++) begin
            v = 6'(i);
            g = ~((v[5] | v[4]) & (v[3] | v[2]) & (v[1] | v[0]));
            r = (m == 1) ? 1'b1 : (m == 2) ? 1'b0 : g;
            if (r != g) begin
                e.err++;
                if (e.vld == 0) begin
                    e.vld = 1;
                    e.vec = i;
                end
            end
        end
        return e;
    endfunction

    task automatic run_sweep(input int m, input bit repulse, input bit all3);
        exp_t e;
        int   b2  = 0;
        int   b1  = 0;
        int   b15 = 0;
        int   cyc = 0;
        bit   fin = 1'b0;
        mode = m;
        sb.push_back(model(m));
        start = 1'b1;
        @(negedge ck);
        start = 1'b0;
        while (!fin && cyc < 2000) begin
            if (sw2.BUSY) begin
                b2++;
                chk("stim_vec", stim2(), (b2 - 1) / 3);
            end
            if (sw1.BUSY)  b1++;
            if (sw15.BUSY) b15++;
            fin = sw2.DONE && !sw2.BUSY &&
                  (!all3 || (sw1.DONE && !sw1.BUSY && sw15.DONE && !sw15.BUSY));
            if (!fin) begin
                start = repulse && (b2 == 50);
                @(negedge ck);
                cyc++;
            end
        end
        start = 1'b0;
        chk("done_seen", int'(fin), 1);
        e = sb.pop_front();
        chk("busy_len", b2, e.busy_len);
        chk("err_cnt", int'(sw2.ERR_CNT), e.err);
        chk("first_vld", int'(sw2.FIRST_ERR_VLD), e.vld);
        chk("first_vec", int'(sw2.FIRST_ERR_VEC), e.vec);
        chk("stim_fin", stim2(), 0);
        if (all3) begin
            chk("busy_len_s1", b1, 128);
            chk("busy_len_s15", b15, 1024);
            chk("err_cnt_s1", int'(sw1.ERR_CNT), 0);
            chk("err_cnt_s15", int'(sw15.ERR_CNT), 0);
        end
        repeat (4) @(negedge ck);
        chk("err_hold", int'(sw2.ERR_CNT), e.err);
        chk("done_hold", int'(sw2.DONE), 1);
        chk("vec_hold", int'(sw2.FIRST_ERR_VEC), e.vec);
    endtask

    initial begin
        int b2;
        int cyc;
        n_tests = 0;
        n_fail  = 0;
        rn      = 1'b0;
        start   = 1'b0;
        mode    = 0;
        repeat (3) @(negedge ck);
        chk("reset_outs", all_out2(), 0);
        rn = 1'b1;
        @(negedge ck);
        chk("idle_outs", all_out2(), 0);

        // Reset and START together: reset must win.
        rn    = 1'b0;
        start = 1'b1;
        @(negedge ck);
        chk("rst_wins_busy", int'(sw2.BUSY), 0);
        rn    = 1'b1;
        start = 1'b0;
        @(negedge ck);
        chk("rst_wins_idle", int'(sw2.BUSY), 0);

        run_sweep(0, 1'b0, 1'b1);
        run_sweep(1, 1'b0, 1'b0);
        run_sweep(2, 1'b0, 1'b0);
        run_sweep(0, 1'b1, 1'b0);

        // Abort a sweep with reset during vector 30, then restart cleanly.
        mode  = 0;
        start = 1'b1;
        @(negedge ck);
        start = 1'b0;
        b2    = 0;
        cyc   = 0;
        while (b2 < 91 && cyc < 400) begin
            if (sw2.BUSY) b2++;
            if (b2 < 91) begin
                @(negedge ck);
                cyc++;
            end
        end
        chk("abort_reached", b2, 91);
        chk("abort_vec", stim2(), 30);
        rn = 1'b0;
        @(negedge ck);
        chk("abort_outs", all_out2(), 0);
        rn = 1'b1;
        repeat (5) @(negedge ck);
        chk("abort_no_restart", int'({sw2.BUSY, sw2.DONE}), 0);
        run_sweep(0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/oai222_vector_sweeper.md
OAI222_VECTOR_SWEEPER -- requirements
Module: oai222_vector_sweeper

Interface
REQ-001 Parameter SETTLE, default 2: number of cycles each vector is held before ZN is sampled; legal range 1..15.
REQ-002 CK  input  1  sole clock; all state updates on rising edge.
REQ-003 RN  input  1  reset, synchronous, active-low.
REQ-004 START  input  1  single-cycle request to begin a 64-vector sweep.
REQ-005 ZN_IN  input  1  output of the OAI222 cell under test.
REQ-006 A1, A2, B1, B2, C1, C2  output  1 each  stimulus driven onto the cell inputs.
REQ-007 BUSY  output  1  sweep in progress.
REQ-008 DONE  output  1  sweep complete, results valid; held as a level.
REQ-009 ERR_CNT  output  7  number of mismatching vectors in the last sweep, range 0..64.
REQ-010 FIRST_ERR_VLD  output  1  at least one mismatch recorded.
REQ-011 FIRST_ERR_VEC  output  6  index of the first mismatching vector.

Function
REQ-012 FSM states: IDLE, DRIVE, CHECK, FIN. All outputs are registered.
REQ-013 Vector index VEC[5:0] maps {A1,A2,B1,B2,C1,C2} = VEC[5:0], with A1 as MSB; vectors are applied in ascending order 0..63.
REQ-014 Expected value is EXP = ~((A1|A2) & (B1|B2) & (C1|C2)) for the applied vector.
REQ-015 In IDLE or FIN, when START=1 the next state is DRIVE with VEC=0 and settle counter=1; ERR_CNT, FIRST_ERR_VLD and FIRST_ERR_VEC clear to 0; DONE clears to 0; BUSY sets to 1.
REQ-016 DRIVE: the settle counter increments each cycle; the FSM moves to CHECK in the cycle after the counter equals SETTLE.
REQ-017 Each vector occupies exactly SETTLE+1 cycles: SETTLE cycles in DRIVE, then 1 cycle in CHECK.
REQ-018 CHECK: ZN_IN is sampled at the closing edge. If ZN_IN != EXP, ERR_CNT increments. If this is also the first mismatch, FIRST_ERR_VEC is set to VEC and FIRST_ERR_VLD is set to 1.
REQ-019 CHECK with VEC<63: VEC increments, the settle counter resets to 1, and the FSM returns to DRIVE.
REQ-020 CHECK with VEC=63: the FSM moves to FIN with BUSY=0 and DONE=1; VEC does not wrap.
REQ-021 Total BUSY duration is 64*(SETTLE+1) cycles (192 cycles at the default setting).
REQ-022 Stimulus outputs follow VEC during DRIVE and CHECK; all six are 0 in IDLE and FIN.
REQ-023 START is ignored while BUSY=1.
REQ-024 ERR_CNT cannot exceed 64, so no saturation logic is required.
REQ-025 Results stay stable in FIN until the next accepted START or reset.

Reset
REQ-026 When RN=0 at a rising edge, the next state is IDLE and every output is 0: BUSY, DONE, ERR_CNT, FIRST_ERR_VLD, FIRST_ERR_VEC and A1..C2.
REQ-027 Reset wins over START in the same cycle.
REQ-028 Reset mid-sweep aborts the sweep with no partial-result retention; a new START is required afterwards.

Verification
REQ-029 Golden cell model on ZN_IN, SETTLE=2, START pulse -> BUSY high for exactly 192 cycles, then DONE=1, ERR_CNT=0, FIRST_ERR_VLD=0.
REQ-030 ZN_IN stuck at 1 -> ERR_CNT=27, FIRST_ERR_VLD=1, FIRST_ERR_VEC=21 (6'b010101).
REQ-031 ZN_IN stuck at 0 -> ERR_CNT=37, FIRST_ERR_VEC=0.
REQ-032 Golden model with START re-pulsed at cycle 50 of a sweep -> START is ignored, the sweep completes at cycle 192, and results match REQ-029.
REQ-033 RN=0 asserted during vector 30, then released, then START -> all outputs are 0 the cycle after reset; the new sweep starts at VEC=0 and returns ERR_CNT=0.
REQ-034 SETTLE=1 and SETTLE=15, golden model -> BUSY lasts 128 and 1024 cycles respectively, with ERR_CNT=0.
